button_conditioner: RTL and testbench

Front-end conditioner for the timer's push-buttons (start, stop, delete, incrementSeconds, incrementMinutes). It synchronises each raw input to the system clock and debounces it. It emits a clean level plus single-cycle press pulses, and optionally auto-repeat pulses while a button is held. It sits directly upstream of the timer state machine and minutes counter, and replaces their direct connection to the board pins.

---
 rtl/button_conditioner.sv | 135 +++++++++++++
 tb/tb_button_conditioner.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser, per-channel debounce, press pulse
// and optional auto-repeat while held. One clock domain, synchronous active-high reset.
module button_conditioner #(
   parameter int unsigned          N_BUTTONS       = 5,
   parameter int unsigned          DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned          REPEAT_DELAY    = 25000000,
   parameter int unsigned          REPEAT_PERIOD   = 5000000,
   parameter logic [N_BUTTONS-1:0] REPEAT_MASK     = 5'b11000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N_BUTTONS-1:0] btn_raw,
   output logic [N_BUTTONS-1:0] btn_level,
   output logic [N_BUTTONS-1:0] btn_pulse,
   output logic                 any_pulse
);

   localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int unsigned DB_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int unsigned RP_W    = (REP_MAX > 2) ? $clog2(REP_MAX) : 1;

   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY - 1);
   localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_DELAY,
      PH_PERIOD
   } phase_e;

   logic [N_BUTTONS-1:0] sync1_q;
   logic [N_BUTTONS-1:0] sync2_q;
   logic [N_BUTTONS-1:0] pulse_d;
   logic                 any_pulse_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
      end
   end

   for (genvar g = 0; g < int'(N_BUTTONS); g++) begin : g_ch
      logic [DB_W-1:0] db_cnt_q, db_cnt_d;
      logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
      phase_e          phase_q, phase_d;
      logic            level_q, level_d;
      logic            pulse_q, ch_pulse_d;
      logic            rise, fall;

      always_comb begin
         db_cnt_d   = db_cnt_q;
         level_d    = level_q;
         phase_d    = phase_q;
         rep_cnt_d  = rep_cnt_q;
         ch_pulse_d = 1'b0;
         rise       = 1'b0;
         fall       = 1'b0;

         if (sync2_q[g] == level_q) begin
            db_cnt_d = '0;
         end else if (db_cnt_q == DB_LAST) begin
            level_d  = sync2_q[g];
            db_cnt_d = '0;
            rise     = sync2_q[g];
            fall     = ~sync2_q[g];
         end else begin
            db_cnt_d = db_cnt_q + 1'b1;
         end

         // A falling level wins over a coincident repeat match: release never pulses.
         if (rise) begin
            ch_pulse_d = 1'b1;
            rep_cnt_d  = '0;
            if (REPEAT_MASK[g]) phase_d = PH_DELAY;
         end else if (fall) begin
            phase_d   = PH_IDLE;
            rep_cnt_d = '0;
         end else if (level_q) begin
            unique case (phase_q)
               PH_DELAY: begin
                  if (rep_cnt_q == RD_LAST) begin
                     ch_pulse_d = 1'b1;
                     rep_cnt_d  = '0;
                     phase_d    = PH_PERIOD;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
               end
               PH_PERIOD: begin
                  if (rep_cnt_q == RP_LAST) begin
                     ch_pulse_d = 1'b1;
                     rep_cnt_d  = '0;
                  end else begin
                     rep_cnt_d = rep_cnt_q + 1'b1;
                  end
               end
               default: rep_cnt_d = '0;
            endcase
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            db_cnt_q  <= '0;
            rep_cnt_q <= '0;
            phase_q   <= PH_IDLE;
            level_q   <= 1'b0;
            pulse_q   <= 1'b0;
         end else begin
            db_cnt_q  <= db_cnt_d;
            rep_cnt_q <= rep_cnt_d;
            phase_q   <= phase_d;
            level_q   <= level_d;
            pulse_q   <= ch_pulse_d;
         end
      end

      assign pulse_d[g]   = ch_pulse_d;
      assign btn_level[g] = level_q;
      assign btn_pulse[g] = pulse_q;
   end

   always_ff @(posedge clk) begin
      if (reset) any_pulse_q <= 1'b0;
      else       any_pulse_q <= |pulse_d;
   end

   assign any_pulse = any_pulse_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner: expected pulses are queued by cycle and
// compared every cycle against btn_pulse/any_pulse; levels are checked inline.
module tb_button_conditioner;

   logic       clk;
   logic       reset;
   logic [4:0] btn_raw;
   logic [4:0] btn_level;
   logic [4:0] btn_pulse;
   logic       any_pulse;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      int         cyc;
      logic [4:0] mask;
   } exp_t;

   exp_t       exp_q[$];
   logic [4:0] exp_mask;

   button_conditioner #(
      .N_BUTTONS      (5),
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (10),
      .REPEAT_PERIOD  (3),
      .REPEAT_MASK    (5'b11000)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw),
      .btn_level(btn_level),
      .btn_pulse(btn_pulse),
      .any_pulse(any_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Sorted insert; pulses expected on the same cycle are merged into one mask.
   function automatic void expect_pulse(input int c, input logic [4:0] m);
      exp_t e;
      e.cyc  = c;
      e.mask = m;
      for (int i = 0; i < exp_q.size(); i++) begin
         if (exp_q[i].cyc == c) begin
            exp_q[i].mask = exp_q[i].mask | m;
            return;
         end
         if (exp_q[i].cyc > c) begin
            exp_q.insert(i, e);
            return;
         end
      end
      exp_q.push_back(e);
   endfunction

   function automatic void expect_repeats(input int p, input int last, input logic [4:0] m);
      expect_pulse(p, m);
      for (int c = p + 10; c <= last; c += 3) expect_pulse(c, m);
   endfunction

   always @(posedge clk) begin
      #1;
      if (cyc >= 1) begin
         exp_mask = '0;
         if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_mask = exp_q[0].mask;
            void'(exp_q.pop_front());
         end
         checks++;
         assert (btn_pulse === exp_mask) else begin
            errors++;
            $error("FAIL pulse@%0d: observed %b expected %b", cyc, btn_pulse, exp_mask);
         end
         checks++;
         assert (any_pulse === (|exp_mask)) else begin
            errors++;
            $error("FAIL any_pulse@%0d: observed %b expected %b", cyc, any_pulse, |exp_mask);
         end
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s@%0d: observed %b expected %b", tag, cyc, obs, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      int p;
      int p2;
      reset   = 1'b1;
      btn_raw = '0;
      wait_until(2);
      check("rst_level", btn_level, 5'b00000);
      check("rst_pulse", btn_pulse, 5'b00000);
      check("rst_any", {4'b0000, any_pulse}, 5'b00000);
      reset = 1'b0;

      // 1: clean press on ch0, no repeats (unmasked), falls 6 edges after release
      wait_until(10);
      t = cyc;
      btn_raw[0] = 1'b1;
      expect_pulse(t + 6, 5'b00001);
      wait_until(t + 5);  check("s1_before_rise", btn_level, 5'b00000);
      wait_until(t + 6);  check("s1_rise", btn_level, 5'b00001);
      wait_until(t + 30); btn_raw[0] = 1'b0;
      wait_until(t + 35); check("s1_before_fall", btn_level, 5'b00001);
      wait_until(t + 36); check("s1_fall", btn_level, 5'b00000);

      // 2: bounce on ch1 restarts the debounce count
      wait_until(t + 50);
      t = cyc;
      btn_raw[1] = 1'b1;
      wait_until(t + 3);  btn_raw[1] = 1'b0;
      wait_until(t + 4);  btn_raw[1] = 1'b1;
      expect_pulse(t + 10, 5'b00010);
      wait_until(t + 9);  check("s2_bounce_low", btn_level, 5'b00000);
      wait_until(t + 10); check("s2_rise", btn_level, 5'b00010);
      wait_until(t + 20); btn_raw[1] = 1'b0;
      wait_until(t + 25); check("s2_before_fall", btn_level, 5'b00010);
      wait_until(t + 26); check("s2_fall", btn_level, 5'b00000);

      // 3: hold ch3, repeat schedule P, P+10, then every 3
      wait_until(t + 40);
      t = cyc;
      p = t + 6;
      btn_raw[3] = 1'b1;
      expect_repeats(p, p + 28, 5'b01000);
      wait_until(p + 24); btn_raw[3] = 1'b0;
      wait_until(p + 29); check("s3_held", btn_level, 5'b01000);
      wait_until(p + 30); check("s3_fall", btn_level, 5'b00000);

      // 4: ch4 level falls exactly on a would-be repeat cycle (P+31)
      wait_until(p + 45);
      t = cyc;
      p = t + 6;
      btn_raw[4] = 1'b1;
      expect_repeats(p, p + 28, 5'b10000);
      wait_until(p + 25); btn_raw[4] = 1'b0;
      wait_until(p + 30); check("s4_held", btn_level, 5'b10000);
      wait_until(p + 31); check("s4_fall_on_repeat", btn_level, 5'b00000);
      wait_until(p + 40);
      t = cyc;
      p2 = t + 6;
      btn_raw[4] = 1'b1;
      expect_repeats(p2, p2 + 19, 5'b10000);
      wait_until(p2);      check("s4_repress", btn_level, 5'b10000);
      wait_until(p2 + 14); btn_raw[4] = 1'b0;
      wait_until(p2 + 20); check("s4_refall", btn_level, 5'b00000);

      // 5: simultaneous press on ch0 and ch3
      wait_until(p2 + 35);
      t = cyc;
      btn_raw = 5'b01001;
      expect_pulse(t + 6, 5'b01001);
      wait_until(t + 6);  check("s5_rise", btn_level, 5'b01001);
      wait_until(t + 8);  btn_raw = 5'b00000;
      wait_until(t + 14); check("s5_fall", btn_level, 5'b00000);

      // 6: reset while ch3 is repeating; held button re-presses after reset
      wait_until(t + 30);
      t = cyc;
      p = t + 6;
      btn_raw[3] = 1'b1;
      expect_repeats(p, p + 16, 5'b01000);
      wait_until(p + 17); reset = 1'b1;
      wait_until(p + 18);
      check("s6_rst_level", btn_level, 5'b00000);
      check("s6_rst_pulse", btn_pulse, 5'b00000);
      wait_until(p + 19);
      check("s6_rst2_level", btn_level, 5'b00000);
      check("s6_rst2_any", {4'b0000, any_pulse}, 5'b00000);
      reset = 1'b0;
      wait_until(p + 20);
      check("s6_post_level", btn_level, 5'b00000);
      check("s6_post_pulse", btn_pulse, 5'b00000);
      p2 = p + 25;
      expect_repeats(p2, p2 + 19, 5'b01000);
      wait_until(p2 - 1); check("s6_before_repress", btn_level, 5'b00000);
      wait_until(p2);     check("s6_repress", btn_level, 5'b01000);
      wait_until(p2 + 14); btn_raw[3] = 1'b0;
      wait_until(p2 + 20); check("s6_fall", btn_level, 5'b00000);
      wait_until(p2 + 30);

      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL queue_drained: observed %0d pending expected 0", exp_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
